// File: rtl/col_serial_collector_if.sv
// Bus bundle between the pixel-array column readout collector and its
// environment: array serial lanes, shift enable, frame control and the
// row/col tagged word stream. The master modport is the collector side.
// Optional macro SUM_MODE_EN adds the sumMode control line.
interface col_serial_collector_if #(
  parameter int Row  = 3,
  parameter int Col  = 3,
  parameter int CntW = 12
);
  localparam int RowW = (Row > 1) ? $clog2(Row) : 1;
  localparam int ColW = (Col > 1) ? $clog2(Col) : 1;

  logic                start;
  logic [Col-1:0]      serOutA;
  logic [Col-1:0]      serOutB;
  logic                shiftEn;
  logic                busy;
  logic                wordValid;
  logic                wordReady;
  logic [2*CntW-1:0]   wordData;
  logic [RowW-1:0]     wordRow;
  logic [ColW-1:0]     wordCol;
  logic                frameDone;
`ifdef SUM_MODE_EN
  logic                sumMode;
`endif

  modport master (
    input  start, serOutA, serOutB, wordReady,
`ifdef SUM_MODE_EN
    input  sumMode,
`endif
    output shiftEn, busy, wordValid, wordData, wordRow, wordCol, frameDone
  );

  modport slave (
    output start, serOutA, serOutB, wordReady,
`ifdef SUM_MODE_EN
    output sumMode,
`endif
    input  shiftEn, busy, wordValid, wordData, wordRow, wordCol, frameDone
  );
endinterface

// File: rtl/col_serial_collector.sv
// Column serial collector for the digital front-end pixel array.
// Drives the array shift enable, deserializes lanes A and B of every
// column (MSB first) one row at a time, then streams one word per pixel
// tagged with row/col on a valid/ready handshake and pulses frameDone.
// Optional macro SUM_MODE_EN: adds sumMode, which selects a zero-extended
// laneA+laneB word instead of the {laneB, laneA} pair.
module col_serial_collector #(
  parameter int Row  = 3,
  parameter int Col  = 3,
  parameter int CntW = 12
) (
  input logic                    i_readClk,
  input logic                    i_resetN,
  col_serial_collector_if.master io_bus
);
  localparam int RowW = (Row > 1) ? $clog2(Row) : 1;
  localparam int ColW = (Col > 1) ? $clog2(Col) : 1;
  localparam int BitW = (CntW > 1) ? $clog2(CntW) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UNLOAD = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            r_state;
  logic [BitW-1:0]   r_bitCnt;
  logic [RowW-1:0]   r_row;
  logic [ColW-1:0]   r_col;
  logic [CntW-1:0]   r_shiftA [Col];
  logic [CntW-1:0]   r_shiftB [Col];
  logic [CntW-1:0]   r_holdA  [Col];
  logic [CntW-1:0]   r_holdB  [Col];
  logic              r_shiftEn;
  logic              r_busy;
  logic              r_wordValid;
  logic              r_frameDone;
  logic [2*CntW-1:0] r_wordData;
  logic [RowW-1:0]   r_wordRow;
  logic [ColW-1:0]   r_wordCol;

  logic [CntW-1:0]   w_nextA [Col];
  logic [CntW-1:0]   w_nextB [Col];
  logic              w_sumMode;
  logic              w_lastBit;
  logic              w_transfer;
  logic              w_lastCol;
  logic              w_lastRow;
  logic [ColW-1:0]   w_nextCol;

`ifdef SUM_MODE_EN
  assign w_sumMode = io_bus.sumMode;
`else
  assign w_sumMode = 1'b0;
`endif

  assign w_lastBit  = (r_bitCnt == BitW'(CntW - 1));
  assign w_transfer = r_wordValid & io_bus.wordReady;
  assign w_lastCol  = (r_col == ColW'(Col - 1));
  assign w_lastRow  = (r_row == RowW'(Row - 1));
  assign w_nextCol  = r_col + ColW'(1);

  // Formats one pixel: the raw lane pair, or the lossless lane sum
  // right-aligned with zero fill when sum mode is selected.
  function automatic logic [2*CntW-1:0] packWord(input logic [CntW-1:0] a,
                                                 input logic [CntW-1:0] b,
                                                 input logic            sum);
    logic [CntW:0] total;
    total = {1'b0, a} + {1'b0, b};
    if (sum) packWord = {{(CntW-1){1'b0}}, total};
    else     packWord = {b, a};
  endfunction

  // Next shift-register contents: each column takes its new bit at the LSB.
  always_comb begin
    for (int c = 0; c < Col; c++) begin
      w_nextA[c] = {r_shiftA[c][CntW-2:0], io_bus.serOutA[c]};
      w_nextB[c] = {r_shiftB[c][CntW-2:0], io_bus.serOutB[c]};
    end
  end

  // Readout sequencer: shift a row in, unload it column by column, repeat
  // per row, then a one-cycle frameDone. All outputs are registered here.
  always_ff @(posedge i_readClk or negedge i_resetN) begin
    if (!i_resetN) begin
      r_state     <= IDLE;
      r_bitCnt    <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_shiftEn   <= 1'b0;
      r_busy      <= 1'b0;
      r_wordValid <= 1'b0;
      r_frameDone <= 1'b0;
      r_wordData  <= '0;
      r_wordRow   <= '0;
      r_wordCol   <= '0;
      for (int c = 0; c < Col; c++) begin
        r_shiftA[c] <= '0;
        r_shiftB[c] <= '0;
        r_holdA[c]  <= '0;
        r_holdB[c]  <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          r_frameDone <= 1'b0;
          if (io_bus.start) begin
            r_state   <= SHIFT;
            r_busy    <= 1'b1;
            r_shiftEn <= 1'b1;
            r_bitCnt  <= '0;
            r_row     <= '0;
          end
        end
        SHIFT: begin
          r_shiftA <= w_nextA;
          r_shiftB <= w_nextB;
          if (w_lastBit) begin
            r_shiftEn   <= 1'b0;
            r_holdA     <= w_nextA;
            r_holdB     <= w_nextB;
            r_col       <= '0;
            r_wordRow   <= r_row;
            r_wordCol   <= '0;
            r_wordData  <= packWord(w_nextA[0], w_nextB[0], w_sumMode);
            r_wordValid <= 1'b1;
            r_state     <= UNLOAD;
          end else begin
            r_bitCnt <= r_bitCnt + BitW'(1);
          end
        end
        UNLOAD: begin
          if (w_transfer) begin
            if (w_lastCol) begin
              r_wordValid <= 1'b0;
              if (w_lastRow) begin
                r_state     <= DONE;
                r_frameDone <= 1'b1;
                r_busy      <= 1'b0;
              end else begin
                r_row     <= r_row + RowW'(1);
                r_bitCnt  <= '0;
                r_shiftEn <= 1'b1;
                r_state   <= SHIFT;
              end
            end else begin
              r_col      <= w_nextCol;
              r_wordCol  <= w_nextCol;
              r_wordData <= packWord(r_holdA[w_nextCol], r_holdB[w_nextCol],
                                     w_sumMode);
            end
          end
        end
        DONE: begin
          r_frameDone <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_bus.shiftEn   = r_shiftEn;
  assign io_bus.busy      = r_busy;
  assign io_bus.wordValid = r_wordValid;
  assign io_bus.wordData  = r_wordData;
  assign io_bus.wordRow   = r_wordRow;
  assign io_bus.wordCol   = r_wordCol;
  assign io_bus.frameDone = r_frameDone;
endmodule

// File: tb/tb_col_serial_collector.sv
// Directed bench for col_serial_collector (Row=3, Col=3, CntW=12) with a
// behavioural pixel-array model feeding the serial lanes. Build with
// SUM_MODE_EN defined to also cover the lane-sum word format.
module tb_col_serial_collector;
  localparam int Row  = 3;
  localparam int Col  = 3;
  localparam int CntW = 12;

  logic clk;
  logic resetN;
  logic modelClear;
  logic arrayMode;
  logic sumOn;
  logic stallOn;
  logic extraStarts;
  logic [CntW-1:0] tmpA;
  logic [CntW-1:0] tmpB;
  int modelCount;
  int rel;
  int wordCount;
  int doneCount;
  int doneRel;
  int firstValidRel;
  int checks;
  int failures;

  col_serial_collector_if #(.Row(Row), .Col(Col), .CntW(CntW)) bus ();

  col_serial_collector #(.Row(Row), .Col(Col), .CntW(CntW)) dut (
    .i_readClk (clk),
    .i_resetN  (resetN),
    .io_bus    (bus)
  );

`ifdef SUM_MODE_EN
  assign bus.sumMode = sumOn;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pixel count held by the array for lane A / lane B.
  function automatic logic [CntW-1:0] laneA(input int r, input int c);
    if (arrayMode) laneA = 12'hFFF;
    else           laneA = CntW'(256 * r + c);
  endfunction

  function automatic logic [CntW-1:0] laneB(input int r, input int c);
    if (arrayMode) laneB = 12'h001;
    else           laneB = CntW'(32'hA00 + 16 * r + c);
  endfunction

  function automatic logic [31:0] expWord(input int r, input int c);
    logic [CntW-1:0] a;
    logic [CntW-1:0] b;
    a = laneA(r, c);
    b = laneB(r, c);
    if (sumOn) expWord = 32'(a) + 32'(b);
    else       expWord = {8'h00, b, a};
  endfunction

  // Array model: one bit advances per edge while shiftEn is high.
  always @(posedge clk or negedge resetN) begin
    if (!resetN)          modelCount <= 0;
    else if (modelClear)  modelCount <= 0;
    else if (bus.shiftEn) modelCount <= modelCount + 1;
  end

  // Serial bits presented by the model, MSB of the nearest row first.
  always_comb begin
    bus.serOutA = '0;
    bus.serOutB = '0;
    tmpA = '0;
    tmpB = '0;
    if (modelCount < Row * CntW) begin
      for (int c = 0; c < Col; c++) begin
        tmpA = laneA(modelCount / CntW, c);
        tmpB = laneB(modelCount / CntW, c);
        bus.serOutA[c] = tmpA[CntW - 1 - (modelCount % CntW)];
        bus.serOutB[c] = tmpB[CntW - 1 - (modelCount % CntW)];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One cycle: drive after the edge, observe at the falling edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
    rel++;
    bus.wordReady = !(stallOn && rel >= 29 && rel <= 33);
    bus.start = extraStarts && (rel == 5 || rel == 13 || rel == 46);
    @(negedge clk);
    if (bus.wordValid && firstValidRel < 0) firstValidRel = rel;
    if (stallOn && rel >= 29 && rel <= 33) begin
      checkOutput("stallValid", 32'(bus.wordValid), 32'd1);
      checkOutput("stallRow", 32'(bus.wordRow), 32'd1);
      checkOutput("stallCol", 32'(bus.wordCol), 32'd1);
      checkOutput("stallData", 32'(bus.wordData), expWord(1, 1));
      checkOutput("stallShiftEn", 32'(bus.shiftEn), 32'd0);
    end
    if (bus.wordValid && bus.wordReady) begin
      checkOutput("wordRow", 32'(bus.wordRow), 32'(wordCount / Col));
      checkOutput("wordCol", 32'(bus.wordCol), 32'(wordCount % Col));
      checkOutput("wordData", 32'(bus.wordData),
                  expWord(wordCount / Col, wordCount % Col));
      wordCount++;
    end
    if (bus.frameDone) begin
      doneCount++;
      doneRel = rel;
    end
  endtask

  task automatic startFrame();
    modelClear = 1'b1;
    @(posedge clk);
    #1;
    modelClear = 1'b0;
    bus.start = 1'b1;
    bus.wordReady = 1'b1;
    rel = 0;
    wordCount = 0;
    doneCount = 0;
    doneRel = -1;
    firstValidRel = -1;
  endtask

  // Runs one complete frame and checks counts and timing at its end.
  task automatic applyStimulus(input logic stall, input logic extra,
                               input int expDone);
    stallOn = stall;
    extraStarts = extra;
    startFrame();
    for (int i = 0; i < 130; i++) begin
      stepCycle();
      if (doneCount > 0 && rel >= doneRel + 3) break;
    end
    checkOutput("wordCount", 32'(wordCount), 32'd9);
    checkOutput("frameDoneCount", 32'(doneCount), 32'd1);
    checkOutput("frameDoneCycle", 32'(doneRel), 32'(expDone));
    checkOutput("firstValidCycle", 32'(firstValidRel), 32'd13);
    checkOutput("idleBusy", 32'(bus.busy), 32'd0);
    checkOutput("idleShiftEn", 32'(bus.shiftEn), 32'd0);
    stallOn = 1'b0;
    extraStarts = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    resetN = 1'b0;
    modelClear = 1'b0;
    arrayMode = 1'b0;
    sumOn = 1'b0;
    stallOn = 1'b0;
    extraStarts = 1'b0;
    rel = 0;
    wordCount = 0;
    doneCount = 0;
    doneRel = -1;
    firstValidRel = -1;
    bus.start = 1'b0;
    bus.wordReady = 1'b0;

    $display("[TB] reset with toggling inputs");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      bus.start = ~bus.start;
      bus.wordReady = ~bus.wordReady;
      @(negedge clk);
      checkOutput("resetOutputs", {bus.shiftEn, bus.busy, bus.wordValid,
                  bus.frameDone, bus.wordData, bus.wordRow, bus.wordCol}, 32'd0);
    end
    bus.start = 1'b0;
    bus.wordReady = 1'b1;
    @(negedge clk);
    resetN = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("postResetShiftEn", 32'(bus.shiftEn), 32'd0);
    checkOutput("postResetBusy", 32'(bus.busy), 32'd0);

    $display("[TB] full frame, ready held high");
    applyStimulus(1'b0, 1'b0, 46);

    $display("[TB] backpressure on word (1,1)");
    applyStimulus(1'b1, 1'b0, 51);

    $display("[TB] start pulses during SHIFT, UNLOAD and DONE");
    applyStimulus(1'b0, 1'b1, 46);

    $display("[TB] reset in the middle of row 1 shifting");
    stallOn = 1'b0;
    extraStarts = 1'b0;
    startFrame();
    repeat (20) stepCycle();
    checkOutput("midShiftEn", 32'(bus.shiftEn), 32'd1);
    checkOutput("midBusy", 32'(bus.busy), 32'd1);
    resetN = 1'b0;
    #1;
    checkOutput("midResetOutputs", {bus.shiftEn, bus.busy, bus.wordValid,
                bus.frameDone, bus.wordData, bus.wordRow, bus.wordCol}, 32'd0);
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 46);

`ifdef SUM_MODE_EN
    $display("[TB] sum mode, saturated lane A");
    arrayMode = 1'b1;
    sumOn = 1'b1;
    applyStimulus(1'b0, 1'b0, 46);
    checkOutput("sumWordValue", expWord(0, 0), 32'h001000);
    sumOn = 1'b0;
    applyStimulus(1'b0, 1'b0, 46);
    checkOutput("pairWordValue", 32'(bus.wordData), 32'h001FFF);
    arrayMode = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
